// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the imem loader.
// The slave side is the loader; the master side is the byte source / memory.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream programmer for the instruction memory: assembles hi/lo bytes
// into 16-bit words, writes them to consecutive addresses, then releases the CPU.
module imem_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start_i,
    input  logic [ADDR_W:0]   load_len_i,
    input  logic              load_abort_i,
    imem_loader_if.slave      bus,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       checksum_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_HI,
        S_RX_LO,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       csum_q, csum_d;
    logic              accept;
    logic              len_bad;

    assign accept  = bus.in_valid & in_ready_q;
    assign len_bad = (load_len_i == '0) || (load_len_i > LEN_MAX);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        count_d    = count_q;
        addr_d     = addr_q;
        hi_d       = hi_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cpu_hold_d = cpu_hold_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        csum_d     = csum_q;

        unique case (state_q)
            S_IDLE: begin
                if (load_start_i) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        len_d      = load_len_i;
                        count_d    = '0;
                        addr_d     = BASE_ADDR;
                        csum_d     = '0;
                        err_d      = 1'b0;
                        busy_d     = 1'b1;
                        cpu_hold_d = 1'b1;
                        state_d    = S_RX_HI;
                    end
                end
            end
            S_RX_HI: begin
                if (load_abort_i) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (accept) begin
                    hi_d    = bus.in_data;
                    state_d = S_RX_LO;
                end
            end
            S_RX_LO: begin
                if (load_abort_i) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (accept) begin
                    wr_addr_d = addr_q;
                    wr_data_d = {hi_q, bus.in_data};
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                // The strobe for this word is already on the bus; an abort
                // here still lets it land and be counted in the checksum.
                csum_d  = csum_q ^ wr_data_q;
                count_d = count_q + 1'b1;
                if (load_abort_i) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (count_q + 1'b1 == len_q) begin
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    cpu_hold_d = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_RX_HI;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_RX_HI) || (state_d == S_RX_LO);
        wr_en_d    = (state_d == S_WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            count_q    <= '0;
            addr_q     <= BASE_ADDR;
            hi_q       <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            csum_q     <= csum_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cpu_hold_o   = cpu_hold_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign checksum_o   = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes and done
// checksums, a negedge monitor pops and compares them as the DUT produces them.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [8:0]  load_len;
    logic        load_abort;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] checksum;

    int errors = 0;
    int checks = 0;
    int n_wr   = 0;
    int exp_wr_total = 0;

    logic [23:0] exp_wr[$];
    logic [15:0] exp_done[$];
    logic [7:0]  bytes[$];

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start_i (load_start),
        .load_len_i   (load_len),
        .load_abort_i (load_abort),
        .bus          (bus),
        .cpu_hold_o   (cpu_hold),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .checksum_o   (checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and done pulse must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                n_wr++;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", {8'h0, bus.wr_addr, bus.wr_data}, 32'hFFFFFFFF);
                end else begin
                    chk("write", {8'h0, bus.wr_addr, bus.wr_data}, {8'h0, exp_wr.pop_front()});
                    chk("wr_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", {16'h0, checksum}, 32'hFFFFFFFF);
                end else begin
                    chk("done_checksum", {16'h0, checksum}, {16'h0, exp_done.pop_front()});
                    chk("done_cpu_hold", {31'b0, cpu_hold}, 32'd0);
                    chk("done_busy", {31'b0, busy}, 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [8:0] len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int   n;
        logic rdy;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        do begin
            rdy = bus.in_ready;
            tick();
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: in_ready=0 expected 1 within 200 cycles");
        end
        bus.in_valid = 1'b0;
    endtask

    // Pushes expected writes/checksum for the bytes queue, then streams it.
    task automatic run_load(input int words, input int max_gap);
        logic [15:0] w;
        logic [15:0] cs;
        cs = 16'h0;
        for (int i = 0; i < words; i++) begin
            w = {bytes[2*i], bytes[2*i+1]};
            cs ^= w;
            exp_wr.push_back({i[7:0], w});
            exp_wr_total++;
        end
        exp_done.push_back(cs);
        start(words[8:0]);
        for (int i = 0; i < 2 * words; i++)
            send_byte(bytes[i], $urandom_range(0, max_gap));
        repeat (4) tick();
        chk("post_cpu_hold", {31'b0, cpu_hold}, 32'd0);
        chk("post_busy", {31'b0, busy}, 32'd0);
        chk("post_checksum", {16'h0, checksum}, {16'h0, cs});
        chk("sb_wr_empty", exp_wr.size(), 0);
        chk("sb_done_empty", exp_done.size(), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        load_start   = 1'b0;
        load_len     = '0;
        load_abort   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // T1: reset mid-load after one write
        exp_wr.push_back({8'h00, 16'h2406});
        exp_wr_total++;
        start(9'd2);
        send_byte(8'h24, 0);
        send_byte(8'h06, 0);
        send_byte(8'h11, 0);
        chk("t1_busy_pre", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("t1_wr_en", {31'b0, bus.wr_en}, 32'd0);
        chk("t1_wr_addr", {24'h0, bus.wr_addr}, 32'd0);
        chk("t1_wr_data", {16'h0, bus.wr_data}, 32'd0);
        chk("t1_busy", {31'b0, busy}, 32'd0);
        chk("t1_done", {31'b0, done}, 32'd0);
        chk("t1_err", {31'b0, err}, 32'd0);
        chk("t1_checksum", {16'h0, checksum}, 32'd0);
        chk("t1_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        chk("t1_sb_empty", exp_wr.size(), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // T2: back-to-back, checksum 0x2830
        bytes = '{8'h24, 8'h06, 8'h08, 8'h16, 8'h04, 8'h20};
        run_load(3, 0);
        chk("t2_checksum", {16'h0, checksum}, 32'h2830);

        // T3: same image with random gaps
        run_load(3, 5);
        chk("t3_checksum", {16'h0, checksum}, 32'h2830);

        // T4: full 256-word image, addresses 0..255
        bytes.delete();
        for (int i = 0; i < 256; i++) begin
            bytes.push_back(i[7:0]);
            bytes.push_back(i[7:0] ^ 8'hA5);
        end
        run_load(256, 0);

        // T5: illegal lengths 0 and 257
        start(9'd0);
        tick();
        chk("t5_err0", {31'b0, err}, 32'd1);
        chk("t5_busy0", {31'b0, busy}, 32'd0);
        chk("t5_hold0", {31'b0, cpu_hold}, 32'd0);
        chk("t5_ready0", {31'b0, bus.in_ready}, 32'd0);
        start(9'd257);
        tick();
        chk("t5_err257", {31'b0, err}, 32'd1);
        chk("t5_busy257", {31'b0, busy}, 32'd0);
        bytes = '{8'h5A, 8'hC3};
        run_load(1, 0);
        chk("t5_err_cleared", {31'b0, err}, 32'd0);

        // T6: abort after hi byte of second word
        exp_wr.push_back({8'h00, 16'h1122});
        exp_wr_total++;
        start(9'd4);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 1);
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        repeat (3) tick();
        chk("t6_err", {31'b0, err}, 32'd1);
        chk("t6_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("t6_sb_empty", exp_wr.size(), 0);
        bytes = '{8'hAB, 8'hCD};
        run_load(1, 0);
        chk("t6_reload_err", {31'b0, err}, 32'd0);

        chk("total_writes", n_wr, exp_wr_total);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
